// File: rtl/mips_pkg.sv
// Shared types for the unified memory path.
// FSM states, grant codes and transfer bundle.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LD  = 1'b1;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  // Loader wins if alone, or on a tie
  // when the CPU owned the last access.
  function automatic logic rr_pick(
    input logic c_req,
    input logic l_req,
    input logic last
  );
    return l_req & (~c_req | (last == GNT_CPU));
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down counter timing one memory access.
// Loads a start value, steps down to zero.
module mem_wait_counter
  import mips_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // load wins over decrement; holds at zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: CPU and loader ports
// sharing one memory, IDLE/ACCESS/DONE FSM.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic [1:0]  state
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'(WAIT_CYCLES - 1);

  state_t st_q;
  state_t st_d;
  logic   grant_q;
  logic   last_q;
  xfer_t  xfer_q;
  xfer_t  win_xfer;
  logic   win;
  logic   start;
  logic   capture;
  logic   cnt_dec;
  logic   cnt_zero;

  assign win = rr_pick(cpu_req, ld_req, last_q);

  // select the winning port's transfer
  always_comb begin
    win_xfer = '{
      we:    cpu_we,
      addr:  cpu_addr,
      wdata: cpu_wdata
    };
    if (win == GNT_LD) begin
      win_xfer = '{
        we:    ld_we,
        addr:  ld_addr,
        wdata: ld_wdata
      };
    end
  end

  mem_wait_counter #(
    .W(CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (start),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  // next-state and per-cycle strobes
  always_comb begin
    st_d    = st_q;
    start   = 1'b0;
    capture = 1'b0;
    cnt_dec = 1'b0;
    case (st_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          st_d  = ACCESS;
          start = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          st_d    = DONE;
          capture = ~xfer_q.we;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        st_d = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // latch winner and its transfer at start
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q <= GNT_CPU;
      last_q  <= GNT_LD;
      xfer_q  <= '0;
    end else if (start) begin
      grant_q <= win;
      last_q  <= win;
      xfer_q  <= win_xfer;
    end
  end

  // read data lands in the owner's register
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else if (capture) begin
      if (grant_q == GNT_CPU) begin
        cpu_rdata <= mem_rdata;
      end else begin
        ld_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (st_q == ACCESS);
  assign mem_we    = mem_en & xfer_q.we;
  assign mem_addr  = xfer_q.addr;
  assign mem_wdata = xfer_q.wdata;

  assign cpu_ready = (st_q == DONE) &
                     (grant_q == GNT_CPU);
  assign ld_ready  = (st_q == DONE) &
                     (grant_q == GNT_LD);

  assign grant = grant_q;
  assign state = st_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Drives and samples on the falling edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_ready;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        grant;
  logic [1:0]  state;

  logic        a_cpu_req, a_cpu_we;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic        a_cpu_ready;
  logic        a_ld_req, a_ld_we;
  logic [31:0] a_ld_addr, a_ld_wdata, a_ld_rdata;
  logic        a_ld_ready;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_grant;
  logic [1:0]  a_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ld_req(ld_req), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ready(ld_ready),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .grant(grant), .state(state)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we),
    .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .ld_req(a_ld_req), .ld_we(a_ld_we),
    .ld_addr(a_ld_addr), .ld_wdata(a_ld_wdata),
    .ld_rdata(a_ld_rdata), .ld_ready(a_ld_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata),
    .grant(a_grant), .state(a_state)
  );

  assign a_mem_rdata = 32'hA5A5_0001;

  logic [31:0] mem [256];
  bit          wr  [256];

  function automatic logic [31:0] preload(
    input logic [7:0] i
  );
    case (i)
      8'd16:   return 32'hDEAD_BEEF;
      8'd32:   return 32'h0BAD_F00D;
      default: return {24'h0, i};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr[mem_addr[9:2]]  <= 1'b1;
    end
  end

  assign mem_rdata = wr[mem_addr[9:2]] ?
    mem[mem_addr[9:2]] : preload(mem_addr[9:2]);

  task automatic run_xfer(
    output int   en_n,
    output int   we_n,
    output int   lat,
    output logic cr,
    output logic lr,
    output bit   to,
    output bit   ovl
  );
    en_n = 0; we_n = 0; lat = 0;
    cr = 1'b0; lr = 1'b0; to = 1'b1; ovl = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_en) en_n++;
      if (mem_we) we_n++;
      if (cpu_ready && ld_ready) ovl = 1'b1;
      if (cpu_ready || ld_ready) begin
        lat = k; cr = cpu_ready; lr = ld_ready;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1; ld_req = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (state !== 2'd0) begin n_fail++;
      $display("FAIL rst_state got %0d want 0", state); end
    n_checks++;
    if (grant !== 1'b0) begin n_fail++;
      $display("FAIL rst_grant got %b want 0", grant); end
    n_checks++;
    if ({mem_en, mem_we} !== 2'b00) begin n_fail++;
      $display("FAIL rst_en_we got %b want 00",
               {mem_en, mem_we}); end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_mem got %h want 0",
               {mem_addr, mem_wdata}); end
    n_checks++;
    if ({cpu_rdata, ld_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_rdata got %h want 0",
               {cpu_rdata, ld_rdata}); end
    n_checks++;
    if ({cpu_ready, ld_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ready got %b want 00",
               {cpu_ready, ld_ready}); end
    cpu_req = 1'b0; ld_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0) begin n_fail++;
      $display("FAIL idle_hold got %0d want 0", state); end
  endtask

  task automatic test_cpu_read();
    int en_n, we_n, lat;
    logic cr, lr;
    bit to, ovl;
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'h40;
    run_xfer(en_n, we_n, lat, cr, lr, to, ovl);
    n_checks++;
    if (to !== 1'b0 || lat !== 3) begin n_fail++;
      $display("FAIL rd_latency got %0d want 3", lat); end
    n_checks++;
    if (en_n !== 2 || we_n !== 0) begin n_fail++;
      $display("FAIL rd_en got en=%0d we=%0d want 2/0",
               en_n, we_n); end
    n_checks++;
    if ({cr, lr} !== 2'b10) begin n_fail++;
      $display("FAIL rd_ready got %b want 10",
               {cr, lr}); end
    n_checks++;
    if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL rd_data got %h want deadbeef",
               cpu_rdata); end
    n_checks++;
    if (mem_en !== 1'b0) begin n_fail++;
      $display("FAIL rd_done_en got %b want 0", mem_en); end
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0 || cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_back_idle got st=%0d rdy=%b",
               state, cpu_ready); end
  endtask

  task automatic test_ld_write();
    int en_n, we_n, lat;
    logic cr, lr;
    bit to, ovl;
    ld_req = 1'b1; ld_we = 1'b1;
    ld_addr = 32'h100; ld_wdata = 32'h1234_5678;
    run_xfer(en_n, we_n, lat, cr, lr, to, ovl);
    n_checks++;
    if (to !== 1'b0 || {cr, lr} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_ready got %b want 01", {cr, lr}); end
    n_checks++;
    if (en_n !== 2 || we_n !== 2) begin n_fail++;
      $display("FAIL wr_we got en=%0d we=%0d want 2/2",
               en_n, we_n); end
    n_checks++;
    if (grant !== 1'b1) begin n_fail++;
      $display("FAIL wr_grant got %b want 1", grant); end
    n_checks++;
    if (mem_addr !== 32'h100 ||
        mem_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wr_bus got %h/%h want 100/12345678",
               mem_addr, mem_wdata); end
    n_checks++;
    if (mem[8'd64] !== 32'h1234_5678) begin n_fail++;
      $display("FAIL wr_mem got %h want 12345678",
               mem[8'd64]); end
    n_checks++;
    if (ld_rdata !== 32'h0) begin n_fail++;
      $display("FAIL wr_rdata got %h want 0", ld_rdata); end
    ld_req = 1'b0; ld_we = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'h100;
    run_xfer(en_n, we_n, lat, cr, lr, to, ovl);
    n_checks++;
    if (to !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL readback got %h want 12345678",
               cpu_rdata); end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int en_n, we_n, lat;
    logic cr, lr;
    bit to, ovl;
    logic [3:0] order;
    order = 4'b1010;
    rst = 1'b0;
    cpu_req = 1'b1; ld_req = 1'b1;
    cpu_we = 1'b0; ld_we = 1'b0;
    cpu_addr = 32'h40; ld_addr = 32'h80;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_xfer(en_n, we_n, lat, cr, lr, to, ovl);
      n_checks++;
      if (to !== 1'b0 || grant !== order[i] ||
          lr !== order[i] || cr !== !order[i]) begin
        n_fail++;
        $display("FAIL rr_%0d got g=%b c=%b l=%b want g=%b",
                 i, grant, cr, lr, order[i]); end
      n_checks++;
      if (ovl !== 1'b0) begin n_fail++;
        $display("FAIL rr_overlap_%0d got 1 want 0", i); end
      n_checks++;
      if (lat !== (i == 0 ? 3 : 4)) begin n_fail++;
        $display("FAIL rr_lat_%0d got %0d want %0d",
                 i, lat, (i == 0 ? 3 : 4)); end
    end
    n_checks++;
    if (cpu_rdata !== 32'hDEAD_BEEF ||
        ld_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rr_data got %h/%h", cpu_rdata,
               ld_rdata); end
    cpu_req = 1'b0; ld_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_change();
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'h40;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd1 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL chg_a1 got st=%0d addr=%h",
               state, mem_addr); end
    cpu_addr = 32'h80; cpu_we = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL chg_a2 got addr=%h we=%b want 40/0",
               mem_addr, mem_we); end
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b1 ||
        cpu_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL chg_done got rdy=%b data=%h",
               cpu_ready, cpu_rdata); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rdy_n;
    cpu_req = 1'b1; cpu_we = 1'b0;
    cpu_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (state !== 2'd1) begin n_fail++;
      $display("FAIL mid_pre got %0d want 1", state); end
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state !== 2'd0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_state got st=%0d en=%b",
               state, mem_en); end
    n_checks++;
    if ({cpu_rdata, ld_rdata} !== 64'h0 ||
        mem_addr !== 32'h0 || grant !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_regs got %h %h %h %b",
               cpu_rdata, ld_rdata, mem_addr, grant); end
    rst = 1'b1;
    rdy_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (cpu_ready || ld_ready) rdy_n++;
    end
    n_checks++;
    if (rdy_n !== 0) begin n_fail++;
      $display("FAIL mid_noready got %0d want 0", rdy_n); end
  endtask

  task automatic test_wait1();
    int en_n, lat;
    en_n = 0; lat = 0;
    a_cpu_req = 1'b1; a_cpu_addr = 32'h40;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (a_mem_en) en_n++;
      if (a_cpu_ready) begin lat = k; break; end
    end
    n_checks++;
    if (lat !== 2 || en_n !== 1) begin n_fail++;
      $display("FAIL w1 got lat=%0d en=%0d want 2/1",
               lat, en_n); end
    n_checks++;
    if (a_cpu_rdata !== 32'hA5A5_0001) begin n_fail++;
      $display("FAIL w1_data got %h want a5a50001",
               a_cpu_rdata); end
    a_cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_state !== 2'd0) begin n_fail++;
      $display("FAIL w1_idle got %0d want 0", a_state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_wdata = '0;
    a_cpu_req = 1'b0; a_cpu_we = 1'b0;
    a_cpu_addr = '0; a_cpu_wdata = '0;
    a_ld_req = 1'b0; a_ld_we = 1'b0;
    a_ld_addr = '0; a_ld_wdata = '0;
    test_reset();
    test_cpu_read();
    test_ld_write();
    test_contention();
    test_addr_change();
    test_reset_mid();
    test_wait1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving memory access cycles per transfer (legal range 1..15).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock; rst  in  1  synchronous reset, active low.
REQ-003 cpu_req  in  1  CPU (multicycle FSM) access request, level, held until cpu_ready.
REQ-004 cpu_we  in  1  CPU write enable; cpu_addr  in  32  byte address; cpu_wdata  in  32  write data.
REQ-005 cpu_rdata  out  32  read data, valid when cpu_ready=1; cpu_ready  out  1  one-cycle completion pulse.
REQ-006 ld_req, ld_we, ld_addr[31:0], ld_wdata[31:0], ld_rdata[31:0], ld_ready: loader/debug port, same widths and meanings as the CPU port.
REQ-007 mem_en  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_rdata  in  32  shared unified memory port.
REQ-008 grant  out  1  owner of current or last access (0=CPU, 1=loader); state  out  2  current FSM state, for debug.

Function
REQ-009 FSM states: IDLE(0), ACCESS(1), DONE(2); encoding 3 unused and SHALL return to IDLE.
REQ-010 IDLE: no request -> stay; any request -> ACCESS next cycle, winner latched into grant.
REQ-011 Arbitration in IDLE: single requester wins; both requesting -> the port not granted last time wins (round-robin via last_grant register).
REQ-012 On IDLE->ACCESS the winner's we/addr/wdata SHALL be registered; mem_* outputs driven only from these registers.
REQ-013 ACCESS: mem_en=1, mem_we=latched we, for exactly WAIT_CYCLES consecutive cycles counted by a wait counter loaded with WAIT_CYCLES-1.
REQ-014 Last ACCESS cycle (counter=0): for reads, mem_rdata SHALL be captured into the winner's rdata register; transition to DONE.
REQ-015 DONE: winner's ready=1 for exactly one cycle, mem_en=0; next state IDLE unconditionally.
REQ-016 Latency: request sampled in IDLE at cycle t -> ready asserted in cycle t+WAIT_CYCLES+1; throughput one access per WAIT_CYCLES+2 cycles.
REQ-017 Writes SHALL leave the corresponding rdata register unchanged.
REQ-018 Requests arriving during ACCESS/DONE SHALL be ignored until IDLE; request changes of the owning port mid-access SHALL NOT alter the latched transfer.
REQ-019 A request still high in IDLE after its ready SHALL be treated as a new access.
REQ-020 cpu_ready and ld_ready SHALL never be asserted in the same cycle; non-winner ready SHALL be 0.
REQ-021 mem_en SHALL be 0 in IDLE and DONE; mem_we SHALL never be 1 while mem_en=0.

Reset
REQ-022 rst=0 at a clock edge SHALL force: state=IDLE, counter=0, grant=0, last_grant=1 (CPU wins first tie), both ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, ld_rdata=0.
REQ-023 Reset during ACCESS or DONE SHALL abort the transfer with no ready pulse; the requester re-issues.
REQ-024 Reset SHALL take priority over all other events on the same edge.

Structure
REQ-025 The state enum (IDLE/ACCESS/DONE) and grant encoding constants (GNT_CPU=0, GNT_LD=1) SHALL reside in the shared package mips_pkg.
REQ-026 The wait counter SHALL be a sub-module mem_wait_counter (load, decrement, zero flag); arbitration and FSM stay in mem_arbiter.

Verification
REQ-027 CPU read: cpu_req=1, cpu_we=0, addr=0x40, memory word 0xDEADBEEF, WAIT_CYCLES=2 -> mem_en high 2 cycles, cpu_ready pulse 3 cycles after request sampled, cpu_rdata=0xDEADBEEF.
REQ-028 Loader write: ld_we=1, addr=0x100, wdata=0x12345678 -> mem_we=1 for 2 cycles with those values, ld_ready pulse, ld_rdata unchanged; readback via CPU returns 0x12345678.
REQ-029 Contention: both requests held after reset -> grant order CPU, loader, CPU, loader; ready pulses never overlap.
REQ-030 Request change mid-access: cpu_addr changed 0x40->0x80 during ACCESS -> mem_addr stays 0x40 throughout.
REQ-031 Reset mid-ACCESS: rst=0 on second ACCESS cycle -> next cycle state=0, mem_en=0, no ready pulse; all outputs at REQ-022 values.
REQ-032 WAIT_CYCLES=1 build: single read -> mem_en exactly 1 cycle, ready 2 cycles after request sampled.
